rpc2_ctrl_adr_wrr_scheduler: RTL and testbench



---
 rtl/rpc2_ctrl_adr_wrr_scheduler_pkg.sv | 21 ++
 rtl/rpc2_ctrl_pipe_reg1.sv | 29 ++
 rtl/rpc2_ctrl_adr_wrr_scheduler.sv | 81 ++++++++
 tb/tb_rpc2_ctrl_adr_wrr_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rpc2_ctrl_adr_wrr_scheduler_pkg.sv
// Shared widths, ADR word bit positions and requester encodings for the ADR scheduler.
package rpc2_ctrl_adr_wrr_scheduler_pkg;

  localparam int unsigned PRE_ADR_DATA_WIDTH  = 46;
  localparam int unsigned ADR_FIFO_DATA_WIDTH = PRE_ADR_DATA_WIDTH + 2;
  localparam int unsigned ADR_RW_BIT          = PRE_ADR_DATA_WIDTH;
  localparam int unsigned ADR_BLK_BIT         = PRE_ADR_DATA_WIDTH + 1;

  localparam logic SEL_RD = 1'b0;
  localparam logic SEL_WR = 1'b1;

  // ADR FIFO word layout: {block, r/w (1 = read), payload}
  function automatic logic [ADR_FIFO_DATA_WIDTH-1:0] pack_adr(
    input logic                          blk,
    input logic                          rw,
    input logic [PRE_ADR_DATA_WIDTH-1:0] payload
  );
    return {blk, rw, payload};
  endfunction

endpackage

// File: rtl/rpc2_ctrl_pipe_reg1.sv
// One-entry valid/data register; accepts a new word whenever empty or draining this cycle.
module rpc2_ctrl_pipe_reg1 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         pop_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         load_en
);

  assign load_en = ~valid | pop_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && pop_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rpc2_ctrl_adr_wrr_scheduler.sv
// Weighted round-robin arbiter sharing the ADR FIFO write port between read and write address streams.
module rpc2_ctrl_adr_wrr_scheduler
  import rpc2_ctrl_adr_wrr_scheduler_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_valid,
  input  logic [PRE_ADR_DATA_WIDTH-1:0]  rd_din,
  output logic                           rd_ready,
  input  logic                           wr_valid,
  input  logic [PRE_ADR_DATA_WIDTH-1:0]  wr_din,
  input  logic                           wr_block,
  output logic                           wr_ready,
  input  logic                           sched_en,
  input  logic [1:0]                     rd_weight,
  input  logic [1:0]                     wr_weight,
  output logic                           adr_wr_en,
  output logic [ADR_FIFO_DATA_WIDTH-1:0] adr_din,
  input  logic                           adr_wr_ready,
  output logic                           sched_owner
);

  logic                           load_en;
  logic                           out_valid;
  logic [ADR_FIFO_DATA_WIDTH-1:0] out_data;
  logic [ADR_FIFO_DATA_WIDTH-1:0] next_word;
  logic                           grant;
  logic                           sel;
  logic                           owner;
  logic [1:0]                     credit;
  logic [1:0]                     w_own;

  // Owner keeps the port while its credit is below its (live) weight; a lone requester always wins.
  always_comb begin
    w_own = owner ? wr_weight : rd_weight;
    sel   = SEL_RD;
    if (rd_valid && wr_valid) begin
      sel = (credit < w_own) ? owner : ~owner;
    end else if (wr_valid) begin
      sel = SEL_WR;
    end
    grant     = ~reset & load_en & sched_en & (rd_valid | wr_valid);
    rd_ready  = grant & (sel == SEL_RD);
    wr_ready  = grant & (sel == SEL_WR);
    next_word = (sel == SEL_WR) ? pack_adr(wr_block, 1'b0, wr_din)
                                : pack_adr(1'b0, 1'b1, rd_din);
  end

  // Owner/credit start exhausted on the write side so the first contended grant goes to read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= SEL_WR;
      credit <= 2'd3;
    end else if (grant) begin
      if (sel == owner) begin
        credit <= (credit == 2'd3) ? credit : credit + 2'd1;
      end else begin
        owner  <= sel;
        credit <= 2'd0;
      end
    end
  end

  rpc2_ctrl_pipe_reg1 #(
    .W (ADR_FIFO_DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (grant),
    .din       (next_word),
    .pop_ready (adr_wr_ready),
    .valid     (out_valid),
    .data      (out_data),
    .load_en   (load_en)
  );

  assign adr_wr_en   = out_valid & adr_wr_ready;
  assign adr_din     = out_data;
  assign sched_owner = owner;

endmodule

// File: tb/tb_rpc2_ctrl_adr_wrr_scheduler.sv
// Directed bench for the ADR WRR scheduler with a run-length arbitration model and literal spot checks.
module tb_rpc2_ctrl_adr_wrr_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_valid, wr_valid, wr_block, sched_en, adr_wr_ready;
  logic [45:0] rd_din, wr_din;
  logic [1:0]  rd_weight, wr_weight;
  logic        rd_ready, wr_ready, adr_wr_en, sched_owner;
  logic [47:0] adr_din;

  int cmp_n = 0;
  int err_n = 0;

  // Model: pending output word plus the side and length of the current grant run.
  bit          m_pend;
  logic [47:0] m_word;
  bit          m_last;
  int          m_run;
  bit          glog[$];
  int          en_cnt = 0;
  int          rdy_cnt = 0;

  rpc2_ctrl_adr_wrr_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .rd_valid     (rd_valid),
    .rd_din       (rd_din),
    .rd_ready     (rd_ready),
    .wr_valid     (wr_valid),
    .wr_din       (wr_din),
    .wr_block     (wr_block),
    .wr_ready     (wr_ready),
    .sched_en     (sched_en),
    .rd_weight    (rd_weight),
    .wr_weight    (wr_weight),
    .adr_wr_en    (adr_wr_en),
    .adr_din      (adr_din),
    .adr_wr_ready (adr_wr_ready),
    .sched_owner  (sched_owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model to the post-edge state.
  always @(negedge clk) begin
    bit exp_en, ld, g, side;
    int w;
    if (reset) begin
      chk("rst_rd_ready", 64'(rd_ready), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_adr_wr_en", 64'(adr_wr_en), 64'd0);
      m_pend = 0;
      m_word = '0;
      m_last = 1;
      m_run  = 99;
    end else begin
      exp_en = m_pend && adr_wr_ready;
      ld     = !m_pend || adr_wr_ready;
      g      = ld && sched_en && (rd_valid || wr_valid);
      w      = m_last ? int'(wr_weight) : int'(rd_weight);
      if (rd_valid && wr_valid) side = (m_run - 1 < w) ? m_last : !m_last;
      else side = wr_valid;
      chk("rd_ready", 64'(rd_ready), 64'(g && !side));
      chk("wr_ready", 64'(wr_ready), 64'(g && side));
      chk("adr_wr_en", 64'(adr_wr_en), 64'(exp_en));
      chk("sched_owner", 64'(sched_owner), 64'(m_last));
      if (m_pend) chk("adr_din", 64'(adr_din), 64'(m_word));
      if (adr_wr_en) en_cnt++;
      if (rd_ready || wr_ready) rdy_cnt++;
      if (g) begin
        m_pend = 1;
        m_word = side ? {wr_block, 1'b0, wr_din} : {1'b0, 1'b1, rd_din};
        glog.push_back(side);
        if (side == m_last) m_run++;
        else begin
          m_last = side;
          m_run  = 1;
        end
      end else if (exp_en) begin
        m_pend = 0;
      end
    end
  end

  initial begin
    bit pat[6];
    int snap_r, snap_e;
    pat = '{0, 0, 1, 0, 0, 1};
    reset = 1; rd_valid = 0; wr_valid = 0; wr_block = 0; sched_en = 1;
    adr_wr_ready = 1; rd_din = '0; wr_din = '0; rd_weight = 0; wr_weight = 0;
    step(3);
    chk("reset_adr_din", 64'(adr_din), 64'd0);
    reset = 0;
    @(negedge clk);
    chk("reset_owner", 64'(sched_owner), 64'd1);
    chk("reset_no_push", 64'(adr_wr_en), 64'd0);
    step(1);

    // Contention with rd_weight=1, wr_weight=0: R,R,W repeating
    rd_weight = 1; wr_weight = 0; rd_valid = 1; wr_valid = 1;
    rd_din = 46'h1AA; wr_din = 46'h2BB;
    glog.delete();
    step(6);
    chk("t1_count", 64'(glog.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_grant%0d", i), 64'(glog[i]), 64'(pat[i]));

    // Write-only stream with block 1
    rd_valid = 0; wr_valid = 1; wr_block = 1; wr_din = 46'h1234;
    step(3);
    @(negedge clk);
    chk("t2_adr_din", 64'(adr_din), 64'h8000_0000_1234);
    chk("t2_push", 64'(adr_wr_en), 64'd1);
    chk("t2_wr_ready", 64'(wr_ready), 64'd1);
    chk("t2_rd_ready", 64'(rd_ready), 64'd0);
    step(1);

    // FIFO backpressure with both valid
    rd_valid = 1; wr_valid = 1; adr_wr_ready = 0;
    snap_r = rdy_cnt;
    step(5);
    chk("t3_no_ready", 64'(rdy_cnt - snap_r), 64'd0);
    chk("t3_hold", 64'(adr_din), 64'h8000_0000_1234);
    adr_wr_ready = 1;
    @(negedge clk);
    chk("t3_push", 64'(adr_wr_en), 64'd1);
    chk("t3_grant_rd", 64'(rd_ready), 64'd1);
    step(1);

    // Weight lowered mid-burst hands the port to write
    rd_weight = 3;
    step(1);
    rd_weight = 0;
    @(negedge clk);
    chk("t4_grant_wr", 64'(wr_ready), 64'd1);
    step(1);

    // Scheduler disabled while a word is pending
    sched_en = 0;
    snap_r = rdy_cnt; snap_e = en_cnt;
    step(5);
    chk("t5_one_push", 64'(en_cnt - snap_e), 64'd1);
    chk("t5_no_grant", 64'(rdy_cnt - snap_r), 64'd0);
    chk("t5_owner", 64'(sched_owner), 64'd1);
    wr_weight = 1; sched_en = 1;
    @(negedge clk);
    chk("t5_resume_wr", 64'(wr_ready), 64'd1);
    step(1);

    // Reset with a word pending discards it immediately
    adr_wr_ready = 1; reset = 1;
    #1;
    chk("t6_push_killed", 64'(adr_wr_en), 64'd0);
    step(2);
    reset = 0; wr_weight = 0; rd_weight = 0;
    @(negedge clk);
    chk("t6_first_rd", 64'(rd_ready), 64'd1);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
